// File: rtl/fft_out_framer.sv
// Output framer for the 4-lane topfft stream: frame timing, per-component requantisation
// with saturation, completed-frame counter and a sticky saturation-event counter.
module fft_out_framer #(
  parameter int NBITS_IN  = 19,
  parameter int NBITS_OUT = 16,
  parameter int SHIFT     = 2,
  parameter int N         = 128,
  parameter int LATENCY   = 9,
  parameter int CNTW      = 16,
  localparam int SLOTW    = $clog2(N/4)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*NBITS_IN-1:0]  in0_up,
  input  logic [2*NBITS_IN-1:0]  in0_down,
  input  logic [2*NBITS_IN-1:0]  in1_up,
  input  logic [2*NBITS_IN-1:0]  in1_down,
  input  logic                   clr_cnt,
  output logic [2*NBITS_OUT-1:0] out0_up,
  output logic [2*NBITS_OUT-1:0] out0_down,
  output logic [2*NBITS_OUT-1:0] out1_up,
  output logic [2*NBITS_OUT-1:0] out1_down,
  output logic                   out_valid,
  output logic                   sof,
  output logic                   eof,
  output logic [SLOTW-1:0]       slot,
  output logic [3:0]             sat_flag,
  output logic [CNTW-1:0]        frame_cnt,
  output logic [CNTW-1:0]        sat_count
);

  localparam int SW = NBITS_IN - SHIFT;
  localparam int LW = $clog2(LATENCY + 1);
  localparam logic [SLOTW-1:0] LAST_SLOT = SLOTW'(N/4 - 1);
  localparam logic signed [SW-1:0] MAXV = SW'((1 << (NBITS_OUT-1)) - 1);
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  typedef enum logic {WAIT, RUN} stateT;

  stateT            state, stateNext;
  logic [LW-1:0]    latCnt, latCntNext;
  logic [8*NBITS_IN-1:0] inFlat;
  logic [NBITS_OUT-1:0]  qComp  [8];
  logic [NBITS_OUT-1:0]  outReg [8];
  logic [7:0]       satComp;
  logic [3:0]       satLane;
  logic [SLOTW-1:0] slotNext;
  logic             run;

  // Component 0 is the LSB (in1_down im); component 7 is in0_up re.
  assign inFlat = {in0_up, in0_down, in1_up, in1_down};

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : gComp
      logic signed [SW-1:0] y;
      logic hi, lo;
      // Taking the upper SW bits is exactly the floor shift by SHIFT.
      assign y  = inFlat[gi*NBITS_IN+SHIFT +: SW];
      assign hi = (y > MAXV);
      assign lo = (y < MINV);
      assign satComp[gi] = hi | lo;
      assign qComp[gi] = hi ? MAXV[NBITS_OUT-1:0] :
                         lo ? MINV[NBITS_OUT-1:0] : y[NBITS_OUT-1:0];
    end
    for (gi = 0; gi < 4; gi++) begin : gLane
      assign satLane[gi] = satComp[2*gi] | satComp[2*gi+1];
    end
  endgenerate

  assign out0_up   = {outReg[7], outReg[6]};
  assign out0_down = {outReg[5], outReg[4]};
  assign out1_up   = {outReg[3], outReg[2]};
  assign out1_down = {outReg[1], outReg[0]};

  assign run      = (state == RUN);
  assign slotNext = out_valid ? slot + 1'b1 : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= WAIT;
      latCnt <= '0;
    end else begin
      state  <= stateNext;
      latCnt <= latCntNext;
    end
  end

  always_comb begin
    stateNext  = state;
    latCntNext = latCnt;
    case (state)
      WAIT: begin
        if (latCnt == LW'(LATENCY - 1)) stateNext = RUN;
        else latCntNext = latCnt + 1'b1;
      end
      RUN:     stateNext = RUN;
      default: stateNext = WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) outReg[i] <= '0;
      out_valid <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      slot      <= '0;
      sat_flag  <= '0;
      frame_cnt <= '0;
      sat_count <= '0;
    end else begin
      if (run) begin
        for (int i = 0; i < 8; i++) outReg[i] <= qComp[i];
        out_valid <= 1'b1;
        slot      <= slotNext;
        sof       <= (slotNext == '0);
        eof       <= (slotNext == LAST_SLOT);
        sat_flag  <= satLane;
        if (slotNext == LAST_SLOT) frame_cnt <= frame_cnt + 1'b1;
      end
      if (clr_cnt) sat_count <= '0;
      else if (run && (|satLane) && (sat_count != '1)) sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_out_framer.sv
// Randomised bench for fft_out_framer: outputs are predicted from the edge count since reset
// release and plain integer arithmetic on the driven component values.
module tb_fft_out_framer;
  localparam int NI = 19;
  localparam int NO = 16;
  localparam int LAT = 9;
  localparam int SLOTS = 32;
  localparam int CW = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2*NI-1:0] in0_up, in0_down, in1_up, in1_down;
  logic clr_cnt;
  logic [2*NO-1:0] out0_up, out0_down, out1_up, out1_down;
  logic out_valid, sof, eof;
  logic [4:0] slot;
  logic [3:0] sat_flag;
  logic [CW-1:0] frame_cnt, sat_count;

  always #5 clk = ~clk;

  fft_out_framer #(.NBITS_IN(NI), .NBITS_OUT(NO), .SHIFT(2), .N(128), .LATENCY(LAT), .CNTW(CW)) dut (
    .clk(clk), .rst(rst),
    .in0_up(in0_up), .in0_down(in0_down), .in1_up(in1_up), .in1_down(in1_down),
    .clr_cnt(clr_cnt),
    .out0_up(out0_up), .out0_down(out0_down), .out1_up(out1_up), .out1_down(out1_down),
    .out_valid(out_valid), .sof(sof), .eof(eof), .slot(slot),
    .sat_flag(sat_flag), .frame_cnt(frame_cnt), .sat_count(sat_count)
  );

  int checks = 0;
  int errors = 0;
  int k = 0;
  int satCntExp = 0;
  int reV[4];
  int imV[4];
  bit clrV;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NI-1:0] to19(input int v);
    return v[NI-1:0];
  endfunction

  // floor(x/4) then clamp to the signed 16-bit range
  function automatic void rq(input int x, output logic [NO-1:0] y, output bit s);
    int f;
    f = (x >= 0) ? x / 4 : -((-x + 3) / 4);
    s = 1'b1;
    if (f > 32767) y = 16'h7FFF;
    else if (f < -32768) y = 16'h8000;
    else begin
      y = f[NO-1:0];
      s = 1'b0;
    end
  endfunction

  function automatic int rnd19(input int mode);
    case (mode)
      0: return int'($urandom_range(0, 2000)) - 1000;
      1: return int'($urandom_range(0, 524287)) - 262144;
      2: return 262143;
      default: return -262144;
    endcase
  endfunction

  task automatic randomInputs(input int satPct);
    for (int l = 0; l < 4; l++) begin
      reV[l] = rnd19(($urandom_range(0, 99) < satPct) ? int'($urandom_range(1, 3)) : 0);
      imV[l] = rnd19(($urandom_range(0, 99) < satPct) ? int'($urandom_range(1, 3)) : 0);
    end
    clrV = ($urandom_range(0, 24) == 0);
  endtask

  task automatic setAll(input int re, input int im);
    for (int l = 0; l < 4; l++) begin
      reV[l] = re;
      imV[l] = im;
    end
    clrV = 1'b0;
  endtask

  task automatic checkZero(input string tag);
    check({tag, ".valid"}, out_valid, 0);
    check({tag, ".sof"}, sof, 0);
    check({tag, ".eof"}, eof, 0);
    check({tag, ".slot"}, slot, 0);
    check({tag, ".flag"}, sat_flag, 0);
    check({tag, ".frame"}, frame_cnt, 0);
    check({tag, ".satcnt"}, sat_count, 0);
    check({tag, ".data"}, {out0_up, out0_down, out1_up, out1_down}, 0);
  endtask

  task automatic step();
    logic [NO-1:0] yr, yi;
    bit sr, si, run;
    logic [2*NO-1:0] dExp [4];
    logic [3:0] fExp;
    int n, slotE, frameE;
    in0_up   = {to19(reV[0]), to19(imV[0])};
    in0_down = {to19(reV[1]), to19(imV[1])};
    in1_up   = {to19(reV[2]), to19(imV[2])};
    in1_down = {to19(reV[3]), to19(imV[3])};
    clr_cnt  = clrV;
    @(posedge clk);
    #1;
    k++;
    run = (k >= LAT + 1);
    fExp = '0;
    for (int l = 0; l < 4; l++) begin
      dExp[l] = '0;
      if (run) begin
        rq(reV[l], yr, sr);
        rq(imV[l], yi, si);
        dExp[l] = {yr, yi};
        if (sr || si) fExp[3-l] = 1'b1;
      end
    end
    if (clrV) satCntExp = 0;
    else if (run && fExp != 0 && satCntExp < CMAX) satCntExp++;
    n = k - (LAT + 1);
    slotE  = run ? n % SLOTS : 0;
    frameE = run ? ((n + 1) / SLOTS) % (CMAX + 1) : 0;
    check($sformatf("valid@k%0d", k), out_valid, run);
    check($sformatf("slot@k%0d", k), slot, slotE);
    check($sformatf("sof@k%0d", k), sof, run && slotE == 0);
    check($sformatf("eof@k%0d", k), eof, run && slotE == SLOTS - 1);
    check($sformatf("frame@k%0d", k), frame_cnt, frameE);
    check($sformatf("flag@k%0d", k), sat_flag, fExp);
    check($sformatf("satcnt@k%0d", k), sat_count, satCntExp);
    check($sformatf("out0_up@k%0d", k), out0_up, dExp[0]);
    check($sformatf("out0_down@k%0d", k), out0_down, dExp[1]);
    check($sformatf("out1_up@k%0d", k), out1_up, dExp[2]);
    check($sformatf("out1_down@k%0d", k), out1_down, dExp[3]);
  endtask

  initial begin
    setAll(0, 0);
    in0_up = '0; in0_down = '0; in1_up = '0; in1_down = '0; clr_cnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkZero("reset");
    rst = 1'b0;
    k = 0;
    satCntExp = 0;

    // saturating inputs while waiting must be ignored
    for (int i = 0; i < LAT; i++) begin
      randomInputs(100);
      clrV = 1'b0;
      step();
    end
    setAll(0, 0);
    step();

    setAll(0, 0);
    reV[0] = 400;
    imV[0] = -3;
    step();

    setAll(0, 0);
    reV[3] = 262143;
    imV[3] = -262144;
    step();

    for (int i = 0; i < 20; i++) begin
      setAll(262143, -262144);
      step();
    end
    setAll(262143, 0);
    clrV = 1'b1;
    step();
    setAll(0, -262144);
    step();

    // long random run spans more than 2^CNTW frames
    for (int i = 0; i < 560; i++) begin
      randomInputs(30);
      step();
    end

    for (int i = 0; i < 40; i++) begin
      if (((k + 1 - (LAT + 1)) % SLOTS) == 10) break;
      randomInputs(30);
      step();
    end
    randomInputs(30);
    step();
    #2 rst = 1'b1;
    #1 checkZero("asyncRst");
    @(posedge clk);
    #1;
    checkZero("holdRst");
    rst = 1'b0;
    k = 0;
    satCntExp = 0;
    for (int i = 0; i < 45; i++) begin
      randomInputs(50);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
